alu_resp_checker: RTL and testbench

Synthesizable response analyzer for the RISC-V ALU. It captures `{rs1, rs2, sel, sal}` samples presented by a stimulus source and recomputes the expected result with an internal reference model. It counts mismatches, records the first failure, and compresses every observed `sal` into a 32-bit MISR signature. It sits opposite the ALU operand/opcode driver: the driver issues operations, and this block judges the answers, for on-chip self-test and for simulation regressions.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_resp_checker_if.sv | 33 +++
 rtl/alu_ref_model.sv | 33 +++
 rtl/alu_resp_checker.sv | 129 ++++++++++++
 tb/tb_alu_resp_checker.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its response checker: opcodes, checker
// FSM states and the MISR constants and update step.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_SLT = 3'd7;

  localparam logic [31:0] MISR_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_e;

  // One MISR step: shift with polynomial feedback, then fold in the new word.
  function automatic logic [31:0] misr_next(input logic [31:0] sig,
                                            input logic [31:0] din);
    return ({sig[30:0], 1'b0} ^ (sig[31] ? MISR_POLY : 32'h0)) ^ din;
  endfunction

endpackage

// File: rtl/alu_resp_checker_if.sv
// Sample bus between the ALU stimulus side and the response checker,
// carrying the sample inputs and the checker's verdict outputs.
interface alu_resp_checker_if #(
  parameter int ERR_W = 16
);
  logic              start;
  logic              in_valid;
  logic [31:0]       rs1;
  logic [31:0]       rs2;
  logic [2:0]        sel;
  logic [31:0]       sal;
  logic              busy;
  logic              done;
  logic              pass;
  logic [ERR_W-1:0]  err_count;
  logic [15:0]       first_err_idx;
  logic [2:0]        first_err_sel;
  logic [31:0]       first_err_exp;
  logic [31:0]       first_err_got;
  logic [31:0]       signature;

  modport master (
    output start, in_valid, rs1, rs2, sel, sal,
    input  busy, done, pass, err_count, first_err_idx, first_err_sel,
           first_err_exp, first_err_got, signature
  );

  modport slave (
    input  start, in_valid, rs1, rs2, sel, sal,
    output busy, done, pass, err_count, first_err_idx, first_err_sel,
           first_err_exp, first_err_got, signature
  );
endinterface

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: recomputes the expected result for an opcode,
// reusable by any bench that needs a reference ALU.
module alu_ref_model
  import alu_pkg::*;
(
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [2:0]  sel,
  output logic [31:0] exp_val
);

  logic signed [31:0] rs1_s;
  logic signed [31:0] rs2_s;

  assign rs1_s = signed'(rs1);
  assign rs2_s = signed'(rs2);

  always_comb begin
    exp_val = 32'h0;
    case (sel)
      OP_ADD:  exp_val = rs1 + rs2;
      OP_SUB:  exp_val = rs1 - rs2;
      OP_AND:  exp_val = rs1 & rs2;
      OP_OR:   exp_val = rs1 | rs2;
      OP_XOR:  exp_val = rs1 ^ rs2;
      OP_SLL:  exp_val = rs1 << rs2[4:0];
      OP_SRL:  exp_val = rs1 >> rs2[4:0];
      OP_SLT:  exp_val = {31'h0, (rs1_s < rs2_s)};
      default: exp_val = 32'h0;
    endcase
  end

endmodule

// File: rtl/alu_resp_checker.sv
// ALU response checker: judges each accepted sample against the reference
// model, counts mismatches, captures the first one and builds a MISR signature.
module alu_resp_checker
  import alu_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  parameter int ERR_W     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_resp_checker_if.slave   bus
);

  localparam logic [15:0]      LAST_IDX = 16'(N_SAMPLES - 1);
  localparam logic [ERR_W-1:0] ERR_ONE  = {{(ERR_W-1){1'b0}}, 1'b1};

  chk_state_e       state_q, state_d;
  logic [15:0]      sample_cnt_q, sample_cnt_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic             have_err_q, have_err_d;
  logic [15:0]      fe_idx_q, fe_idx_d;
  logic [2:0]       fe_sel_q, fe_sel_d;
  logic [31:0]      fe_exp_q, fe_exp_d;
  logic [31:0]      fe_got_q, fe_got_d;
  logic [31:0]      sig_q, sig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [31:0]      exp_val;

  alu_ref_model u_ref (
    .rs1     (bus.rs1),
    .rs2     (bus.rs2),
    .sel     (bus.sel),
    .exp_val (exp_val)
  );

  always_comb begin
    state_d      = state_q;
    sample_cnt_d = sample_cnt_q;
    err_count_d  = err_count_q;
    have_err_d   = have_err_q;
    fe_idx_d     = fe_idx_q;
    fe_sel_d     = fe_sel_q;
    fe_exp_d     = fe_exp_q;
    fe_got_d     = fe_got_q;
    sig_d        = sig_q;

    case (state_q)
      // start outranks in_valid here, so a colliding sample is dropped
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d      = ST_RUN;
          sample_cnt_d = '0;
          err_count_d  = '0;
          have_err_d   = 1'b0;
          fe_idx_d     = '0;
          fe_sel_d     = '0;
          fe_exp_d     = '0;
          fe_got_d     = '0;
          sig_d        = MISR_SEED;
        end
      end
      ST_RUN: begin
        if (bus.in_valid) begin
          if (exp_val != bus.sal) begin
            if (err_count_q != '1) err_count_d = err_count_q + ERR_ONE;
            if (!have_err_q) begin
              have_err_d = 1'b1;
              fe_idx_d   = sample_cnt_q;
              fe_sel_d   = bus.sel;
              fe_exp_d   = exp_val;
              fe_got_d   = bus.sal;
            end
          end
          sig_d        = misr_next(sig_q, bus.sal);
          sample_cnt_d = sample_cnt_q + 16'd1;
          if (sample_cnt_q == LAST_IDX) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    pass_d = (state_d == ST_DONE) && (err_count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sample_cnt_q <= '0;
      err_count_q  <= '0;
      have_err_q   <= 1'b0;
      fe_idx_q     <= '0;
      fe_sel_q     <= '0;
      fe_exp_q     <= '0;
      fe_got_q     <= '0;
      sig_q        <= MISR_SEED;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sample_cnt_q <= sample_cnt_d;
      err_count_q  <= err_count_d;
      have_err_q   <= have_err_d;
      fe_idx_q     <= fe_idx_d;
      fe_sel_q     <= fe_sel_d;
      fe_exp_q     <= fe_exp_d;
      fe_got_q     <= fe_got_d;
      sig_q        <= sig_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.err_count     = err_count_q;
  assign bus.first_err_idx = fe_idx_q;
  assign bus.first_err_sel = fe_sel_q;
  assign bus.first_err_exp = fe_exp_q;
  assign bus.first_err_got = fe_got_q;
  assign bus.signature     = sig_q;

endmodule

// File: tb/tb_alu_resp_checker.sv
// Bench for alu_resp_checker: directed runs against a behavioural model,
// plus literal expectations and a second instance for counter saturation.
module tb_alu_resp_checker;
  import alu_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_resp_checker_if #(.ERR_W(16)) bus ();
  alu_resp_checker_if #(.ERR_W(2))  bus_s ();

  alu_resp_checker #(.N_SAMPLES(8), .ERR_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  alu_resp_checker #(.N_SAMPLES(6), .ERR_W(2)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Golden arithmetic, written from the opcode table.
  function automatic logic [31:0] ref_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] op);
    int unsigned sh;
    sh = b % 32;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << sh;
      3'd6: return a >> sh;
      default: return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Behavioural model: phase 0 idle, 1 running, 2 finished.
  int          m_phase = 0;
  int          m_cnt   = 0;
  int          m_err   = 0;
  bit          m_have  = 0;
  bit          m_live  = 0;
  logic [31:0] m_idx = 0, m_sel = 0, m_exp = 0, m_got = 0;
  logic [31:0] m_sig = 32'hFFFF_FFFF;

  always @(posedge clk) begin
    logic [31:0] e;
    logic [31:0] s;
    if (!rst_n) begin
      m_phase = 0; m_cnt = 0; m_err = 0; m_have = 0; m_live = 1;
      m_idx = 0; m_sel = 0; m_exp = 0; m_got = 0; m_sig = 32'hFFFF_FFFF;
    end else if (m_phase != 1) begin
      if (bus.start) begin
        m_phase = 1; m_cnt = 0; m_err = 0; m_have = 0;
        m_idx = 0; m_sel = 0; m_exp = 0; m_got = 0; m_sig = 32'hFFFF_FFFF;
      end
    end else if (bus.in_valid) begin
      e = ref_calc(bus.rs1, bus.rs2, bus.sel);
      if (e != bus.sal) begin
        if (m_err < 65535) m_err++;
        if (!m_have) begin
          m_have = 1; m_idx = m_cnt; m_sel = 32'(bus.sel); m_exp = e; m_got = bus.sal;
        end
      end
      s = m_sig << 1;
      if (m_sig[31]) s = s ^ 32'h04C1_1DB7;
      m_sig = s ^ bus.sal;
      m_cnt++;
      if (m_cnt == 8) m_phase = 2;
    end
    #1;
    if (m_live) begin
      chk("busy",      32'(bus.busy), (m_phase == 1) ? 32'd1 : 32'd0);
      chk("done",      32'(bus.done), (m_phase == 2) ? 32'd1 : 32'd0);
      chk("pass",      32'(bus.pass), (m_phase == 2 && m_err == 0) ? 32'd1 : 32'd0);
      chk("err_count", 32'(bus.err_count), 32'(m_err));
      chk("fe_idx",    32'(bus.first_err_idx), m_idx);
      chk("fe_sel",    32'(bus.first_err_sel), m_sel);
      chk("fe_exp",    bus.first_err_exp, m_exp);
      chk("fe_got",    bus.first_err_got, m_got);
      chk("signature", bus.signature, m_sig);
    end
  end

  logic [31:0] sweep_sal [8] = '{32'd233, 32'd219, 32'd2, 32'd231, 32'd229, 32'd28928, 32'd1, 32'd0};

  task automatic do_start();
    @(negedge clk);
    bus.start = 1'b1; bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                      input logic [31:0] r);
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b1;
    bus.rs1 = a; bus.rs2 = b; bus.sel = op; bus.sal = r;
  endtask

  task automatic gap();
    @(negedge clk);
    bus.start = 1'b0; bus.in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] sweep_sig;
    logic [31:0] held;
    bus.start = 0; bus.in_valid = 0; bus.rs1 = 0; bus.rs2 = 0; bus.sel = 0; bus.sal = 0;
    bus_s.start = 0; bus_s.in_valid = 0; bus_s.rs1 = 0; bus_s.rs2 = 0; bus_s.sel = 0; bus_s.sal = 0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err",  32'(bus.err_count), 32'd0);
    chk("rst_sig",  bus.signature, 32'hFFFF_FFFF);
    rst_n = 1'b1;

    // Opcode sweep, all correct
    do_start();
    for (int i = 0; i < 8; i++) send(32'd226, 32'd7, 3'(i), sweep_sal[i]);
    gap();
    chk("sweep_done", 32'(bus.done), 32'd1);
    chk("sweep_pass", 32'(bus.pass), 32'd1);
    chk("sweep_err",  32'(bus.err_count), 32'd0);
    sweep_sig = bus.signature;

    // Injected fault on the OR sample
    do_start();
    for (int i = 0; i < 8; i++) send(32'd226, 32'd7, 3'(i), (i == 3) ? 32'd230 : sweep_sal[i]);
    gap();
    chk("fault_err",  32'(bus.err_count), 32'd1);
    chk("fault_idx",  32'(bus.first_err_idx), 32'd3);
    chk("fault_sel",  32'(bus.first_err_sel), 32'd3);
    chk("fault_exp",  bus.first_err_exp, 32'd231);
    chk("fault_got",  bus.first_err_got, 32'd230);
    chk("fault_pass", 32'(bus.pass), 32'd0);

    // Signed and wrap-around edge cases, all correct
    do_start();
    send(32'hFFFF_FFFF, 32'd1,          OP_SLT, 32'd1);
    send(32'hFFFF_FFFF, 32'd1,          OP_ADD, 32'd0);
    send(32'd1,         32'd33,         OP_SLL, 32'd2);
    send(32'd0,         32'd1,          OP_SUB, 32'hFFFF_FFFF);
    send(32'h8000_0000, 32'd31,         OP_SRL, 32'd1);
    send(32'd1,         32'hFFFF_FFFF,  OP_SLT, 32'd0);
    send(32'hF0F0_F0F0, 32'h0FF0_0FF0,  OP_XOR, 32'hFF00_FF00);
    send(32'hF0F0_F0F0, 32'h0FF0_0FF0,  OP_AND, 32'h00F0_00F0);
    gap();
    chk("edge_pass", 32'(bus.pass), 32'd1);
    chk("edge_err",  32'(bus.err_count), 32'd0);

    // Start collides with a (wrong) sample, then samples with gaps
    @(negedge clk);
    bus.start = 1'b1; bus.in_valid = 1'b1;
    bus.rs1 = 32'd1; bus.rs2 = 32'd1; bus.sel = OP_ADD; bus.sal = 32'd7;
    for (int i = 0; i < 8; i++) begin
      send(32'd226, 32'd7, 3'(i), sweep_sal[i]);
      if (i < 4) begin
        gap();
        held = bus.signature;
        gap();
        chk("gap_sig_hold", bus.signature, held);
        chk("gap_not_done", 32'(bus.done), 32'd0);
      end
    end
    gap();
    chk("gap_done", 32'(bus.done), 32'd1);
    chk("gap_pass", 32'(bus.pass), 32'd1);
    chk("gap_sig",  bus.signature, sweep_sig);

    // Reset in the middle of a run
    do_start();
    for (int i = 0; i < 4; i++) send(32'd226, 32'd7, 3'(i), (i == 1) ? 32'd5 : sweep_sal[i]);
    @(negedge clk);
    chk("pre_rst_err", 32'(bus.err_count), 32'd1);
    rst_n = 1'b0; bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_err",  32'(bus.err_count), 32'd0);
    chk("mid_rst_sig",  bus.signature, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    do_start();
    for (int i = 0; i < 8; i++) send(32'd226, 32'd7, 3'(i), sweep_sal[i]);
    gap();
    chk("rerun_sig",  bus.signature, sweep_sig);
    chk("rerun_pass", 32'(bus.pass), 32'd1);

    // Saturating error counter on the narrow instance
    @(negedge clk);
    bus_s.start = 1'b1;
    @(negedge clk);
    bus_s.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      bus_s.in_valid = 1'b1; bus_s.rs1 = 32'd226; bus_s.rs2 = 32'd7;
      bus_s.sel = 3'(i); bus_s.sal = 32'h0000_DEAD;
      @(negedge clk);
    end
    bus_s.in_valid = 1'b0;
    chk("sat_done", 32'(bus_s.done), 32'd1);
    chk("sat_err",  32'(bus_s.err_count), 32'd3);
    chk("sat_idx",  32'(bus_s.first_err_idx), 32'd0);
    chk("sat_exp",  bus_s.first_err_exp, 32'd233);
    chk("sat_got",  bus_s.first_err_got, 32'h0000_DEAD);
    chk("sat_pass", 32'(bus_s.pass), 32'd0);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
